// File: rtl/dp_control_unit_pkg.sv
// Shared encodings for the data-processing control unit: ALU operation
// selects, ARM DP opcodes, condition codes, MUL sequencer states and the
// condition-evaluation helper.
package dp_control_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_RSB  = 4'b0010,
        ALU_ADC  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_ORR  = 4'b0101,
        ALU_EOR  = 4'b0110,
        ALU_BIC  = 4'b0111,
        ALU_MOV  = 4'b1000,
        ALU_MVN  = 4'b1001,
        ALU_SBC  = 4'b1010,
        ALU_RSC  = 4'b1011,
        ALU_MULP = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_EOR = 4'b0001,
        CMD_SUB = 4'b0010,
        CMD_RSB = 4'b0011,
        CMD_ADD = 4'b0100,
        CMD_ADC = 4'b0101,
        CMD_SBC = 4'b0110,
        CMD_RSC = 4'b0111,
        CMD_TST = 4'b1000,
        CMD_TEQ = 4'b1001,
        CMD_CMP = 4'b1010,
        CMD_CMN = 4'b1011,
        CMD_ORR = 4'b1100,
        CMD_MOV = 4'b1101,
        CMD_BIC = 4'b1110,
        CMD_MVN = 4'b1111
    } dp_cmd_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    // FlagW encodings: bit 1 writes N,Z; bit 0 writes C,V
    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

    // Flags are ordered {N, Z, C, V}; the never-condition (1111) always fails
    function automatic logic cond_passed(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic result;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_MI: result = n;
            COND_PL: result = ~n;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_HI: result = c & ~z;
            COND_LS: result = ~c | z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = ~z & (n == v);
            COND_LE: result = z | (n != v);
            COND_AL: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dp_control_unit_cond_check.sv
// Condition-field evaluator: compares the instruction condition against the
// registered NZCV flags and reports whether the instruction executes.
module dp_control_unit_cond_check
    import dp_control_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    // Pure table lookup on the current flags
    always_comb begin
        cond_ex = cond_passed(cond, flags);
    end

endmodule

// File: rtl/dp_control_unit.sv
// Data-processing control unit: decodes the 16 ARM DP commands, gates flag
// and register writes on the condition field, holds the NZCV register and
// sequences the iterative multiplier through IDLE -> RUN -> DONE.
module dp_control_unit
    import dp_control_unit_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        cond,
    input  logic [4:0]        funct4_0,
    input  logic              ALUOp,
    input  logic              is_mul,
    input  logic [3:0]        alu_flags,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [1:0]        FlagW,
    output logic              NoWrite,
    output logic              CondEx,
    output logic [3:0]        Flags,
    output logic              busy,
    output logic              mul_step,
    output logic              mul_done
);

    localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    mul_state_e       state;
    logic [CNT_W-1:0] counter;
    logic             mul_s;
    alu_ctrl_e        alu_ctrl;
    logic [1:0]       flag_w_dec;
    logic             no_write_dec;
    logic [3:0]       cmd;
    logic             s_bit;
    logic             issue;

    assign cmd     = funct4_0[4:1];
    assign s_bit   = funct4_0[0];
    assign ready_o = ~busy;
    assign issue   = valid_i & ready_o & CondEx;

    dp_control_unit_cond_check u_cond_check (
        .cond    (cond),
        .flags   (Flags),
        .cond_ex (CondEx)
    );

    // Raw decode: the MUL sequencer owns the outputs while busy, otherwise the DP command table applies
    always_comb begin
        alu_ctrl     = ALU_ADD;
        flag_w_dec   = FLAGW_NONE;
        no_write_dec = 1'b0;
        if (state == ST_RUN) begin
            alu_ctrl     = ALU_MULP;
            no_write_dec = 1'b1;
        end else if (state == ST_DONE) begin
            alu_ctrl     = ALU_MULP;
            flag_w_dec   = mul_s ? FLAGW_NZ : FLAGW_NONE;
        end else if (is_mul) begin
            alu_ctrl     = ALU_MULP;
            no_write_dec = 1'b1;
        end else if (ALUOp) begin
            case (cmd)
                CMD_AND: begin alu_ctrl = ALU_AND; flag_w_dec = s_bit ? FLAGW_NZ  : FLAGW_NONE; end
                CMD_EOR: begin alu_ctrl = ALU_EOR; flag_w_dec = s_bit ? FLAGW_NZ  : FLAGW_NONE; end
                CMD_SUB: begin alu_ctrl = ALU_SUB; flag_w_dec = s_bit ? FLAGW_ALL : FLAGW_NONE; end
                CMD_RSB: begin alu_ctrl = ALU_RSB; flag_w_dec = s_bit ? FLAGW_ALL : FLAGW_NONE; end
                CMD_ADD: begin alu_ctrl = ALU_ADD; flag_w_dec = s_bit ? FLAGW_ALL : FLAGW_NONE; end
                CMD_ADC: begin alu_ctrl = ALU_ADC; flag_w_dec = s_bit ? FLAGW_ALL : FLAGW_NONE; end
                CMD_SBC: begin alu_ctrl = ALU_SBC; flag_w_dec = s_bit ? FLAGW_ALL : FLAGW_NONE; end
                CMD_RSC: begin alu_ctrl = ALU_RSC; flag_w_dec = s_bit ? FLAGW_ALL : FLAGW_NONE; end
                CMD_TST: begin alu_ctrl = ALU_AND; flag_w_dec = FLAGW_NZ;  no_write_dec = 1'b1; end
                CMD_TEQ: begin alu_ctrl = ALU_EOR; flag_w_dec = FLAGW_NZ;  no_write_dec = 1'b1; end
                CMD_CMP: begin alu_ctrl = ALU_SUB; flag_w_dec = FLAGW_ALL; no_write_dec = 1'b1; end
                CMD_CMN: begin alu_ctrl = ALU_ADD; flag_w_dec = FLAGW_ALL; no_write_dec = 1'b1; end
                CMD_ORR: begin alu_ctrl = ALU_ORR; flag_w_dec = s_bit ? FLAGW_NZ  : FLAGW_NONE; end
                CMD_MOV: begin alu_ctrl = ALU_MOV; flag_w_dec = s_bit ? FLAGW_NZ  : FLAGW_NONE; end
                CMD_BIC: begin alu_ctrl = ALU_BIC; flag_w_dec = s_bit ? FLAGW_NZ  : FLAGW_NONE; end
                CMD_MVN: begin alu_ctrl = ALU_MVN; flag_w_dec = s_bit ? FLAGW_NZ  : FLAGW_NONE; end
                default: begin alu_ctrl = ALU_ADD; flag_w_dec = FLAGW_NONE; end
            endcase
        end
    end

    // A failed condition in IDLE turns the instruction into a no-op; a running MUL already passed its check
    always_comb begin
        ALUControl = CTRL_W'(alu_ctrl);
        FlagW      = flag_w_dec;
        NoWrite    = no_write_dec;
        if ((state == ST_IDLE) && !CondEx) begin
            FlagW   = FLAGW_NONE;
            NoWrite = 1'b1;
        end
    end

    // NZCV register: DP instructions update on issue, a flag-setting MUL updates only N,Z at writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else if (state == ST_DONE) begin
            if (mul_s) begin
                Flags[3:2] <= alu_flags[3:2];
            end
        end else if (issue && !is_mul) begin
            if (FlagW[1]) begin
                Flags[3:2] <= alu_flags[3:2];
            end
            if (FlagW[0]) begin
                Flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    // MUL sequencer with registered busy/step/done so downstream sees glitch-free controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            counter  <= '0;
            mul_s    <= 1'b0;
            busy     <= 1'b0;
            mul_step <= 1'b0;
            mul_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue && is_mul) begin
                        state    <= ST_RUN;
                        counter  <= '0;
                        mul_s    <= s_bit;
                        busy     <= 1'b1;
                        mul_step <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (counter == CNT_LAST) begin
                        state    <= ST_DONE;
                        mul_step <= 1'b0;
                        mul_done <= 1'b1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    mul_done <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    mul_step <= 1'b0;
                    mul_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_control_unit.sv
// Scoreboard bench for dp_control_unit: stimulus pushes hand-computed
// expectations into queues, a negedge monitor pops and compares them.
module tb_dp_control_unit;

    localparam int CTRL_W  = 4;
    localparam int MUL_LAT = 4;

    logic              clk;
    logic              reset;
    logic              valid_i;
    logic              ready_o;
    logic [3:0]        cond;
    logic [4:0]        funct4_0;
    logic              alu_op;
    logic              is_mul;
    logic [3:0]        alu_flags;
    logic [CTRL_W-1:0] alu_control;
    logic [1:0]        flag_w;
    logic              no_write;
    logic              cond_ex;
    logic [3:0]        flags;
    logic              busy;
    logic              mul_step;
    logic              mul_done;

    typedef struct {
        string       name;
        logic [15:0] val;
    } chk_t;

    typedef struct {
        string name;
        int    steps;
        int    busy_cycles;
    } mul_t;

    chk_t exp_q[$];
    mul_t mul_q[$];

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int step_cnt = 0;
    int unexpected_done = 0;

    logic [15:0] act;
    assign act = {alu_control, flag_w, no_write, cond_ex, flags, ready_o, busy, mul_step, mul_done};

    logic [3:0] ctrl_tab [16] = '{4'b0100, 4'b0110, 4'b0001, 4'b0010, 4'b0000, 4'b0011, 4'b1010, 4'b1011,
                                  4'b0100, 4'b0110, 4'b0001, 4'b0000, 4'b0101, 4'b1000, 4'b0111, 4'b1001};
    logic [1:0] fw_s1_tab [16] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                                   2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};

    dp_control_unit #(
        .CTRL_W  (CTRL_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .cond       (cond),
        .funct4_0   (funct4_0),
        .ALUOp      (alu_op),
        .is_mul     (is_mul),
        .alu_flags  (alu_flags),
        .ALUControl (alu_control),
        .FlagW      (flag_w),
        .NoWrite    (no_write),
        .CondEx     (cond_ex),
        .Flags      (flags),
        .busy       (busy),
        .mul_step   (mul_step),
        .mul_done   (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs an expected output vector in the same order as act
    function automatic logic [15:0] ex(input logic [3:0] ctrl, input logic [1:0] fw, input logic nw,
                                       input logic ce, input logic [3:0] fl, input logic rdy,
                                       input logic b, input logic s, input logic d);
        return {ctrl, fw, nw, ce, fl, rdy, b, s, d};
    endfunction

    task automatic checkOutput(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic applyStimulus(input string nm, input logic v, input logic [3:0] c, input logic [4:0] f,
                                 input logic aop, input logic mul, input logic [3:0] af,
                                 input logic [15:0] want);
        chk_t e;
        @(posedge clk);
        #1;
        valid_i   = v;
        cond      = c;
        funct4_0  = f;
        alu_op    = aop;
        is_mul    = mul;
        alu_flags = af;
        e.name = nm;
        e.val  = want;
        exp_q.push_back(e);
    endtask

    task automatic expectMul(input string nm, input int steps, input int busy_cycles);
        mul_t m;
        m.name        = nm;
        m.steps       = steps;
        m.busy_cycles = busy_cycles;
        mul_q.push_back(m);
    endtask

    // Monitor: counts MUL activity, scores each mul_done, then drains pending output checks
    always @(negedge clk) begin
        chk_t c;
        mul_t m;
        if (reset) begin
            busy_cnt = 0;
            step_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (mul_step) step_cnt++;
            if (mul_done) begin
                if (mul_q.size() == 0) begin
                    unexpected_done++;
                end else begin
                    m = mul_q.pop_front();
                    checkOutput(m.name, {8'(step_cnt), 8'(busy_cnt)}, {8'(m.steps), 8'(m.busy_cycles)});
                end
                busy_cnt = 0;
                step_cnt = 0;
            end
        end
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            checkOutput(c.name, act, c.val);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        chk_t e;
        logic is_test;
        logic [1:0] fw;
        reset     = 1'b1;
        valid_i   = 1'b0;
        cond      = 4'b1110;
        funct4_0  = 5'b00000;
        alu_op    = 1'b0;
        is_mul    = 1'b0;
        alu_flags = 4'b0000;
        #1;
        e.name = "reset_state";
        e.val  = ex(4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(e);
        #11;
        reset = 1'b0;

        $display("[TB] flag update and condition gating");
        applyStimulus("adds",      1, 4'b1110, 5'b01001, 1, 0, 4'b0110, ex(4'b0000, 2'b11, 0, 1, 4'b0000, 1, 0, 0, 0));
        applyStimulus("adds_flag", 0, 4'b1110, 5'b00000, 0, 0, 4'b0000, ex(4'b0000, 2'b00, 0, 1, 4'b0110, 1, 0, 0, 0));
        applyStimulus("subne",     1, 4'b0001, 5'b00101, 1, 0, 4'b1001, ex(4'b0001, 2'b00, 1, 0, 4'b0110, 1, 0, 0, 0));
        applyStimulus("subne_kep", 0, 4'b1110, 5'b00000, 0, 0, 4'b0000, ex(4'b0000, 2'b00, 0, 1, 4'b0110, 1, 0, 0, 0));
        applyStimulus("cmp_nz",    1, 4'b1110, 5'b10100, 1, 0, 4'b1000, ex(4'b0001, 2'b11, 1, 1, 4'b0110, 1, 0, 0, 0));
        applyStimulus("beq_skip",  1, 4'b0000, 5'b01000, 1, 0, 4'b1111, ex(4'b0000, 2'b00, 1, 0, 4'b1000, 1, 0, 0, 0));
        applyStimulus("cmp_z",     1, 4'b1110, 5'b10100, 1, 0, 4'b0100, ex(4'b0001, 2'b11, 1, 1, 4'b1000, 1, 0, 0, 0));
        applyStimulus("beq_take",  1, 4'b0000, 5'b01001, 1, 0, 4'b1111, ex(4'b0000, 2'b11, 0, 1, 4'b0100, 1, 0, 0, 0));
        applyStimulus("movs",      1, 4'b1110, 5'b11011, 1, 0, 4'b0000, ex(4'b1000, 2'b10, 0, 1, 4'b1111, 1, 0, 0, 0));
        applyStimulus("movs_flag", 0, 4'b1110, 5'b00000, 0, 0, 4'b0000, ex(4'b0000, 2'b00, 0, 1, 4'b0011, 1, 0, 0, 0));

        $display("[TB] MULS sequence");
        applyStimulus("muls_issue", 1, 4'b1110, 5'b00001, 1, 1, 4'b0000, ex(4'b1100, 2'b00, 1, 1, 4'b0011, 1, 0, 0, 0));
        expectMul("muls_timing", MUL_LAT, MUL_LAT + 1);
        for (int i = 0; i < MUL_LAT; i++) begin
            applyStimulus($sformatf("muls_run%0d", i), 1, 4'b1110, 5'b00001, 1, 1, 4'b0000,
                          ex(4'b1100, 2'b00, 1, 1, 4'b0011, 0, 1, 1, 0));
        end
        applyStimulus("muls_done",  1, 4'b1110, 5'b00001, 1, 1, 4'b1011, ex(4'b1100, 2'b10, 0, 1, 4'b0011, 0, 1, 0, 1));
        applyStimulus("muls_flags", 0, 4'b1110, 5'b00000, 0, 0, 4'b0000, ex(4'b0000, 2'b00, 0, 1, 4'b1011, 1, 0, 0, 0));
        applyStimulus("mul_skip",   1, 4'b0000, 5'b00001, 1, 1, 4'b0100, ex(4'b1100, 2'b00, 1, 0, 4'b1011, 1, 0, 0, 0));
        applyStimulus("mul_skip2",  0, 4'b1110, 5'b00000, 0, 0, 4'b0000, ex(4'b0000, 2'b00, 0, 1, 4'b1011, 1, 0, 0, 0));

        $display("[TB] reset during MUL");
        applyStimulus("mul2_issue", 1, 4'b1110, 5'b00000, 1, 1, 4'b0000, ex(4'b1100, 2'b00, 1, 1, 4'b1011, 1, 0, 0, 0));
        applyStimulus("mul2_run0",  1, 4'b1110, 5'b00000, 1, 1, 4'b0000, ex(4'b1100, 2'b00, 1, 1, 4'b1011, 0, 1, 1, 0));
        @(posedge clk);
        #2;
        reset = 1'b1;
        e.name = "rst_mid_mul";
        e.val  = ex(4'b1100, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        is_mul   = 1'b0;
        alu_op   = 1'b0;
        funct4_0 = 5'b00000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus("after_rst", 0, 4'b1110, 5'b00000, 0, 0, 4'b0000, ex(4'b0000, 2'b00, 0, 1, 4'b0000, 1, 0, 0, 0));

        $display("[TB] command sweep");
        for (int c = 0; c < 16; c++) begin
            for (int s = 0; s < 2; s++) begin
                is_test = (c >= 8) && (c <= 11);
                fw = (s == 1 || is_test) ? fw_s1_tab[c] : 2'b00;
                applyStimulus($sformatf("cmd%0d_s%0d", c, s), 0, 4'b1110, {4'(c), 1'(s)}, 1, 0, 4'b0000,
                              ex(ctrl_tab[c], fw, is_test, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end
        applyStimulus("cond_nv", 0, 4'b1111, 5'b01001, 1, 0, 4'b0000, ex(4'b0000, 2'b00, 1, 0, 4'b0000, 1, 0, 0, 0));
        applyStimulus("cond_ge", 0, 4'b1010, 5'b01001, 1, 0, 4'b0000, ex(4'b0000, 2'b11, 0, 1, 4'b0000, 1, 0, 0, 0));
        applyStimulus("cond_le", 0, 4'b1101, 5'b01001, 1, 0, 4'b0000, ex(4'b0000, 2'b00, 1, 0, 4'b0000, 1, 0, 0, 0));
        applyStimulus("cond_cc", 0, 4'b0011, 5'b01001, 1, 0, 4'b0000, ex(4'b0000, 2'b11, 0, 1, 4'b0000, 1, 0, 0, 0));

        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("mul_pending", 16'(mul_q.size()), 16'd0);
        checkOutput("mul_unexpected", 16'(unexpected_done), 16'd0);
        checkOutput("exp_pending", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
